flash_spi_ctrl: RTL and testbench



---
 rtl/flash_spi_pkg.sv | 20 ++
 rtl/spi_shift8.sv | 89 ++++++++
 rtl/flash_spi_ctrl.sv | 105 ++++++++++
 tb/tb_flash_spi_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_spi_pkg.sv
// Shared constants and types for the flash SPI master port.
// Optional idle-read dummy fetch is enabled by FLASH_SPI_READ_TRIGGER_EN.
package flash_spi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [BYTE_W-1:0] CS_ADDR_DEF   = 8'h01;
  localparam logic [BYTE_W-1:0] DATA_ADDR_DEF = 8'h02;
  localparam logic [BYTE_W-1:0] DUMMY_BYTE    = 8'hFF;

  // Last phase index of a byte: 8 bits x 2 phases
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * BYTE_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_shift8.sv
// 8-bit SPI mode-0 shifter, MSB first, one bit per two clk cycles.
module spi_shift8
  import flash_spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] tx,
  input  logic              miso,
  output logic              busy,
  output logic [BYTE_W-1:0] rx,
  output logic              sclk,
  output logic              mosi
);

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] tx_q, tx_d;
  logic [BYTE_W-2:0] rxsh_q, rxsh_d;
  logic [BYTE_W-1:0] rx_q, rx_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= DUMMY_BYTE;
      rxsh_q  <= '1;
      rx_q    <= '1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rxsh_q  <= rxsh_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  // Even phase counts are the low half of a bit, odd ones the high half
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rxsh_d  = rxsh_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sclk_d  = 1'b0;
          mosi_d  = tx[BYTE_W-1];
          tx_d    = {tx[BYTE_W-2:0], 1'b0};
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!cnt_q[0]) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          rxsh_d = {rxsh_q[BYTE_W-3:0], miso};
          if (cnt_q == LAST_CNT) begin
            // MOSI keeps the last bit sent while idle
            state_d = IDLE;
            rx_d    = {rxsh_q, miso};
          end else begin
            mosi_d = tx_q[BYTE_W-1];
            tx_d   = {tx_q[BYTE_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign rx   = rx_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;

endmodule

// File: rtl/flash_spi_ctrl.sv
// Memory-mapped SPI master for the configuration/ROM flash: CS/status and data registers.
// Define FLASH_SPI_READ_TRIGGER_EN to make idle data-register reads fetch the next byte.
module flash_spi_ctrl
  import flash_spi_pkg::*;
#(
  parameter logic [BYTE_W-1:0] CS_ADDR   = CS_ADDR_DEF,
  parameter logic [BYTE_W-1:0] DATA_ADDR = DATA_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              oe_n,
  output logic              flash_cs_n,
  output logic              flash_clk,
  output logic              flash_di,
  input  logic              flash_do
);

  logic              cs_sel, data_sel;
  logic              wr_cs, wr_data;
  logic              wr_cs_q, wr_data_q;
  logic              wr_cs_fire, wr_data_fire;
  logic              cs_n_q;
  logic              busy;
  logic              start;
  logic [BYTE_W-1:0] tx;
  logic [BYTE_W-1:0] rx;

  assign cs_sel   = (addr == CS_ADDR);
  assign data_sel = (addr == DATA_ADDR);
  assign wr_cs    = wr & cs_sel;
  assign wr_data  = wr & data_sel;

  assign wr_cs_fire   = wr_cs & ~wr_cs_q;
  assign wr_data_fire = wr_data & ~wr_data_q;

  // Strobe history for edge qualification, plus the chip-select register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cs_q   <= 1'b0;
      wr_data_q <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      wr_cs_q   <= wr_cs;
      wr_data_q <= wr_data;
      if (wr_cs_fire) begin
        cs_n_q <= din[0];
      end
    end
  end

`ifdef FLASH_SPI_READ_TRIGGER_EN
  logic rd_data, rd_data_q, rd_data_fire;

  assign rd_data      = rd & data_sel;
  assign rd_data_fire = rd_data & ~rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= 1'b0;
    end else begin
      rd_data_q <= rd_data;
    end
  end

  // A write wins over a simultaneous read trigger
  assign start = (wr_data_fire | rd_data_fire) & ~busy;
  assign tx    = wr_data_fire ? din : DUMMY_BYTE;
`else
  assign start = wr_data_fire & ~busy;
  assign tx    = din;
`endif

  spi_shift8 u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .tx    (tx),
    .miso  (flash_do),
    .busy  (busy),
    .rx    (rx),
    .sclk  (flash_clk),
    .mosi  (flash_di)
  );

  assign flash_cs_n = cs_n_q;
  assign oe_n       = ~(rd & (cs_sel | data_sel));

  // Read mux merged into the CPU bus; idles high when not driving
  always_comb begin
    dout = '1;
    if (!oe_n) begin
      if (cs_sel) begin
        dout = {6'b0, busy, cs_n_q};
      end else begin
        dout = rx;
      end
    end
  end

endmodule

// File: tb/tb_flash_spi_ctrl.sv
// Randomized directed bench for flash_spi_ctrl with a byte-level SPI flash model.
module tb_flash_spi_ctrl;

  localparam logic [7:0] CS_A  = 8'h01;
  localparam logic [7:0] DATA_A = 8'h02;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr  = 8'h00;
  logic [7:0] din   = 8'h00;
  logic       rd    = 1'b0;
  logic       wr    = 1'b0;
  logic [7:0] dout;
  logic       oe_n;
  logic       flash_cs_n;
  logic       flash_clk;
  logic       flash_di;
  logic       flash_do;

  int unsigned checks    = 0;
  int unsigned errors    = 0;
  int unsigned rises     = 0;
  int unsigned falls     = 0;
  int unsigned fall_base = 0;
  logic [7:0]  mosi_cap   = 8'h00;
  logic [7:0]  slave_byte = 8'hFF;
  logic [7:0]  model_rx   = 8'hFF;
  logic [2:0]  bit_idx;

  flash_spi_ctrl #(.CS_ADDR(CS_A), .DATA_ADDR(DATA_A)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .rd         (rd),
    .wr         (wr),
    .din        (din),
    .dout       (dout),
    .oe_n       (oe_n),
    .flash_cs_n (flash_cs_n),
    .flash_clk  (flash_clk),
    .flash_di   (flash_di),
    .flash_do   (flash_do)
  );

  always #5 clk = ~clk;

  // Flash model: captures MOSI on rising SCLK, presents next MISO bit after falling SCLK
  always @(posedge flash_clk) begin
    rises    = rises + 1;
    mosi_cap = {mosi_cap[6:0], flash_di};
  end

  always @(negedge flash_clk) falls = falls + 1;

  assign bit_idx  = 3'(7 - (falls - fall_base));
  assign flash_do = slave_byte[bit_idx];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_slave(input logic [7:0] b);
    slave_byte = b;
    fall_base  = falls;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; din = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] d, output logic oe);
    @(negedge clk);
    addr = a; rd = 1'b1;
    #1;
    d  = dout;
    oe = oe_n;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic xfer_write(input logic [7:0] tx, input logic [7:0] sb);
    int unsigned base;
    load_slave(sb);
    base = rises;
    write_reg(DATA_A, tx);
    cycles(20);
    check("xfer_clks", 8'(rises - base), 8'd8);
    check("xfer_mosi", mosi_cap, tx);
    check("xfer_di_hold", {7'b0, flash_di}, {7'b0, tx[0]});
    model_rx = sb;
  endtask

  task automatic read_data(input string tag);
    logic [7:0]  nb;
    logic [7:0]  d;
    logic        oe;
    int unsigned base;
    nb = 8'($urandom);
    load_slave(nb);
    base = rises;
    read_reg(DATA_A, d, oe);
    check({tag, "_dout"}, d, model_rx);
    check({tag, "_oe"}, {7'b0, oe}, 8'd0);
    cycles(20);
`ifdef FLASH_SPI_READ_TRIGGER_EN
    check({tag, "_dummy_clks"}, 8'(rises - base), 8'd8);
    check({tag, "_dummy_mosi"}, mosi_cap, 8'hFF);
    model_rx = nb;
`else
    check({tag, "_no_clks"}, 8'(rises - base), 8'd0);
`endif
  endtask

  initial begin
    logic [7:0]  d;
    logic        oe;
    int unsigned base;
    int unsigned busy_cnt;
    logic        first_busy;
    logic [7:0]  sb;
    logic [7:0]  t1;
    logic [7:0]  t2;
    int          k;

    // Reset values
    cycles(2);
    check("rst_cs_n", {7'b0, flash_cs_n}, 8'd1);
    check("rst_sclk", {7'b0, flash_clk}, 8'd0);
    check("rst_di", {7'b0, flash_di}, 8'd1);
    check("rst_oe_n", {7'b0, oe_n}, 8'd1);
    check("rst_dout", dout, 8'hFF);
    rst_n = 1'b1;

    read_reg(CS_A, d, oe);
    check("status_rst", d, 8'h01);
    check("status_oe", {7'b0, oe}, 8'd0);
    #1;
    check("idle_oe_n", {7'b0, oe_n}, 8'd1);
    check("idle_dout", dout, 8'hFF);

    // Chip select
    write_reg(CS_A, 8'h00);
    check("cs_low", {7'b0, flash_cs_n}, 8'd0);
    read_reg(CS_A, d, oe);
    check("status_cs_low", d, 8'h00);

    // Write strobe held well past completion: one transfer, first rise two cycles in
    load_slave(8'h3C);
    base = rises;
    @(negedge clk);
    addr = DATA_A; din = 8'hAA; wr = 1'b1;
    @(negedge clk);
    check("lat_low", {7'b0, flash_clk}, 8'd0);
    @(negedge clk);
    check("lat_high", {7'b0, flash_clk}, 8'd1);
    cycles(30);
    wr = 1'b0;
    check("held_wr_clks", 8'(rises - base), 8'd8);
    check("held_wr_mosi", mosi_cap, 8'hAA);
    check("held_wr_di_hold", {7'b0, flash_di}, 8'd0);
    model_rx = 8'h3C;
    read_data("aa_rx");

    // Busy window seen through the status register
    sb = 8'($urandom);
    load_slave(sb);
    @(negedge clk);
    addr = DATA_A; din = 8'h55; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; addr = CS_A; rd = 1'b1;
    busy_cnt   = 0;
    first_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (i == 0) first_busy = dout[1];
      if (dout[1] === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    rd = 1'b0;
    check("busy_first", {7'b0, first_busy}, 8'd1);
    check("busy_len", 8'(busy_cnt), 8'd16);
    check("busy_mosi", mosi_cap, 8'h55);
    model_rx = sb;
    read_data("busy_rx");

    // MISO held high, then a known pattern
    xfer_write(8'h00, 8'hFF);
    read_data("ones");
    xfer_write(8'hC3, 8'h5A);
    read_data("pat5a");

    // Second write mid-transfer is ignored
    sb = 8'($urandom);
    t1 = 8'($urandom);
    t2 = ~t1;
    load_slave(sb);
    base = rises;
    write_reg(DATA_A, t1);
    cycles(5);
    write_reg(DATA_A, t2);
    cycles(20);
    check("mid_clks", 8'(rises - base), 8'd8);
    check("mid_mosi", mosi_cap, t1);
    model_rx = sb;
    read_data("mid");

    // Read strobe held across completion
    sb = 8'($urandom);
    load_slave(sb);
    base = rises;
    @(negedge clk);
    addr = DATA_A; rd = 1'b1;
    #1;
    check("held_rd_dout", dout, model_rx);
    cycles(40);
    rd = 1'b0;
`ifdef FLASH_SPI_READ_TRIGGER_EN
    check("held_rd_clks", 8'(rises - base), 8'd8);
    model_rx = sb;
`else
    check("held_rd_clks", 8'(rises - base), 8'd0);
`endif

    // Random traffic
    for (int n = 0; n < 6; n++) begin
      xfer_write(8'($urandom), 8'($urandom));
      read_data("rand");
    end

    // Reset in the middle of bit 4
    sb = 8'($urandom);
    load_slave(sb);
    base = rises;
    write_reg(DATA_A, 8'($urandom));
    k = 0;
    while ((rises - base) < 4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_reached", 8'(rises - base), 8'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_sclk", {7'b0, flash_clk}, 8'd0);
    check("rst_mid_cs_n", {7'b0, flash_cs_n}, 8'd1);
    check("rst_mid_di", {7'b0, flash_di}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_rx = 8'hFF;
    read_reg(CS_A, d, oe);
    check("rst_mid_status", d, 8'h01);
    read_data("rst_mid_rx");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
